io_uart_txq: RTL

IO_UART_TXQ -- requirements
Module: io_uart_txq

---
 rtl/io_uart_txq.sv | 118 +++++++++++
 1 files changed

// File: rtl/io_uart_txq.sv
// Dual-slot UART transmit queue: two byte write ports feed a circular buffer drained by one emitter.
// Optional build macro UART_TXQ_CRLF_EN expands a queued 0x0A into the pair 0x0D, 0x0A on output.
module io_uart_txq #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  a_wr,
  input  logic [7:0]            a_data,
  input  logic                  b_wr,
  input  logic [7:0]            b_data,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   lvl_t;

  localparam lvl_t DEPTH_L = lvl_t'(DEPTH);

  logic [7:0] r_mem [DEPTH];
  ptr_t       r_wptr;
  ptr_t       r_rptr;
  lvl_t       r_level;
  logic       r_overflow;

  lvl_t       w_free;
  logic       w_a_ok;
  logic       w_b_ok;
  logic       w_drop;
  logic [1:0] w_push_cnt;
  ptr_t       w_b_slot;
  logic [7:0] w_head;
  logic       w_hs;
  logic       w_pop;

  // Capacity uses the pre-pop occupancy, so a same-cycle pop never makes room for a push.
  always_comb begin
    w_free     = DEPTH_L - r_level;
    w_a_ok     = a_wr && (w_free != '0);
    w_b_ok     = b_wr && (w_a_ok ? (w_free >= lvl_t'(2)) : (w_free != '0));
    w_drop     = (a_wr && !w_a_ok) || (b_wr && !w_b_ok);
    w_push_cnt = {1'b0, w_a_ok} + {1'b0, w_b_ok};
    w_b_slot   = w_a_ok ? (r_wptr + ptr_t'(1)) : r_wptr;
  end

  always_ff @(posedge clk) begin
    if (w_a_ok) begin
      r_mem[r_wptr] <= a_data;
    end
    if (w_b_ok) begin
      r_mem[w_b_slot] <= b_data;
    end
  end

  always_comb begin
    w_head   = r_mem[r_rptr];
    tx_valid = (r_level != '0);
    w_hs     = tx_valid && tx_ready;
  end

`ifdef UART_TXQ_CRLF_EN
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CR_SENT = 1'b1;

  logic [0:0] r_crlf_state;
  logic       w_ins_cr;

  // A line feed at the head is first presented as a carriage return without leaving the queue.
  always_comb begin
    w_ins_cr = (r_crlf_state == ST_IDLE) && (w_head == 8'h0A);
    w_pop    = w_hs && !w_ins_cr;
    tx_data  = w_ins_cr ? 8'h0D : w_head;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_crlf_state <= ST_IDLE;
    end else if (w_hs) begin
      r_crlf_state <= w_ins_cr ? ST_CR_SENT : ST_IDLE;
    end
  end
`else
  always_comb begin
    w_pop   = w_hs;
    tx_data = w_head;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wptr     <= r_wptr + ptr_t'(w_push_cnt);
      if (w_pop) begin
        r_rptr <= r_rptr + ptr_t'(1);
      end
      r_level    <= r_level + lvl_t'(w_push_cnt) - lvl_t'(w_pop);
      r_overflow <= r_overflow | w_drop;
    end
  end

  always_comb begin
    full     = (w_free < lvl_t'(2));
    level    = r_level;
    overflow = r_overflow;
  end

endmodule
